adder_n_fifo: RTL and testbench

Parametrised N-channel buffered adder: each of NUM_IN input streams has its own synchronous FIFO behind a valid/ready port. One element is joined from every channel and the sum is written into an output FIFO behind a valid/ready port. It generalises the two-input buffered adder to any channel count, and adds optional saturation, a sticky overflow flag and an output occupancy count. It sits between independent producers and a single consumer in the datapath.

---
 rtl/adder_n_fifo_if.sv | 23 ++
 rtl/adder_n_fifo.sv | 79 +++++++
 tb/tb_adder_n_fifo.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_n_fifo_if.sv
// adder_n_fifo_if: per-channel input streams, summed output stream and status of the N-channel adder
interface adder_n_fifo_if #(
  parameter int DW = 16,
  parameter int NUM_IN = 4,
  parameter int CW = 5
);
  logic [NUM_IN*DW-1:0] in_data;
  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_ready;
  logic [DW-1:0] s_data;
  logic s_valid;
  logic s_ready;
  logic [CW-1:0] out_count;
  logic ovf;
  modport master (
    output in_data, in_valid, s_ready,
    input in_ready, s_data, s_valid, out_count, ovf
  );
  modport slave (
    input in_data, in_valid, s_ready,
    output in_ready, s_data, s_valid, out_count, ovf
  );
endinterface

// File: rtl/adder_n_fifo.sv
// adder_n_fifo: N-channel buffered adder with per-channel input FIFOs, a joined sum and an output FIFO
module adder_n_fifo #(
  parameter int DW = 16,
  parameter int NUM_IN = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int SAT = 0
) (
  input logic clk,
  input logic rstn,
  adder_n_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = DW + $clog2(NUM_IN);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] MAX = {DW{1'b1}};
  logic [DW-1:0] mem [NUM_IN][FIFO_DEPTH];
  logic [DW-1:0] omem [FIFO_DEPTH];
  logic [NUM_IN-1:0][AW-1:0] wr, rd;
  logic [NUM_IN-1:0][CW-1:0] cnt, cnt_nx;
  logic [NUM_IN-1:0] rdy, push, nonempty;
  logic [AW-1:0] owr, ord;
  logic [CW-1:0] ocnt, ocnt_nx;
  logic [SW-1:0] acc;
  logic [DW-1:0] sum;
  logic join_en, pop, over, ovf, valid;
  // join decision uses only registered counts, so an output pop cannot unblock a full output FIFO
  always_comb begin
    acc = '0;
    nonempty = '0;
    cnt_nx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      nonempty[i] = cnt[i] != '0;
      acc = acc + SW'(mem[i][rd[i]]);
    end
    join_en = (&nonempty) && (ocnt < FULL);
    for (int i = 0; i < NUM_IN; i++)
      cnt_nx[i] = cnt[i] + CW'(push[i]) - CW'(join_en);
    over = acc > SW'(MAX);
    sum = (SAT != 0 && over) ? MAX : acc[DW-1:0];
  end
  assign push = bus.in_valid & bus.in_ready;
  assign valid = ocnt != '0;
  assign pop = valid & bus.s_ready;
  assign ocnt_nx = ocnt + CW'(join_en) - CW'(pop);
  assign bus.in_ready = rdy & {NUM_IN{rstn}};
  assign bus.s_valid = valid;
  assign bus.s_data = valid ? omem[ord] : '0;
  assign bus.out_count = ocnt;
  assign bus.ovf = ovf;
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++)
      if (push[i]) mem[i][wr[i]] <= bus.in_data[i*DW +: DW];
    if (join_en) omem[owr] <= sum;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      rdy <= '0;
      owr <= '0;
      ord <= '0;
      ocnt <= '0;
      ovf <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (push[i]) wr[i] <= wr[i] + 1'b1;
        if (join_en) rd[i] <= rd[i] + 1'b1;
        rdy[i] <= cnt_nx[i] < FULL;
      end
      cnt <= cnt_nx;
      if (join_en) owr <= owr + 1'b1;
      if (pop) ord <= ord + 1'b1;
      ocnt <= ocnt_nx;
      ovf <= ovf | (join_en & over);
    end
  end
endmodule

// File: tb/tb_adder_n_fifo.sv
// tb_adder_n_fifo: checks the N-channel adder with vector tables, directed sequences and a scoreboard
module tb_adder_n_fifo;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  adder_n_fifo_if #(.DW(16), .NUM_IN(2), .CW(5)) b2();
  adder_n_fifo_if #(.DW(16), .NUM_IN(2), .CW(5)) b2s();
  adder_n_fifo_if #(.DW(16), .NUM_IN(4), .CW(5)) b4();
  assign b2s.in_data = b2.in_data;
  assign b2s.in_valid = b2.in_valid;
  assign b2s.s_ready = b2.s_ready;
  adder_n_fifo #(.DW(16), .NUM_IN(2), .FIFO_DEPTH(16), .SAT(0)) u2 (.clk(clk), .rstn(rstn), .bus(b2.slave));
  adder_n_fifo #(.DW(16), .NUM_IN(2), .FIFO_DEPTH(16), .SAT(1)) u2s (.clk(clk), .rstn(rstn), .bus(b2s.slave));
  adder_n_fifo #(.DW(16), .NUM_IN(4), .FIFO_DEPTH(16), .SAT(0)) u4 (.clk(clk), .rstn(rstn), .bus(b4.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    b2.in_valid = '0;
    b4.in_valid = '0;
    b2.s_ready = 1'b0;
    b4.s_ready = 1'b0;
    tick();
    chk("ready_in_reset", b4.in_ready, 0);
    rstn = 1'b1;
    tick();
  endtask

  // scoreboard for the 4-channel instance: accepted inputs per channel, joined into expected sums
  int unsigned q4 [4][$];
  int unsigned e4 [$];
  int push4 [4];
  int pops4;
  logic hold4;
  logic [15:0] held4;
  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        q4[i].delete();
        push4[i] = 0;
      end
      e4.delete();
      pops4 = 0;
      hold4 = 1'b0;
    end else begin
      if (hold4) chk("hold4", {b4.s_valid, b4.s_data}, {1'b1, held4});
      if (b4.s_valid && b4.s_ready) begin
        pops4++;
        if (e4.size() == 0) chk("extra_out4", b4.s_data, 32'hDEAD_BEEF);
        else chk("sum4", b4.s_data, e4.pop_front());
      end
      for (int i = 0; i < 4; i++)
        if (b4.in_valid[i] && b4.in_ready[i]) begin
          q4[i].push_back(32'(b4.in_data[i*16 +: 16]));
          push4[i]++;
        end
      while (q4[0].size() > 0 && q4[1].size() > 0 && q4[2].size() > 0 && q4[3].size() > 0) begin
        int unsigned s;
        s = 0;
        for (int i = 0; i < 4; i++) s += q4[i].pop_front();
        e4.push_back(s & 32'hFFFF);
      end
      hold4 = b4.s_valid && !b4.s_ready;
      held4 = b4.s_data;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] wrap;
    logic [15:0] sat;
    logic ovf;
  } vec_t;
  vec_t tv [5];

  initial begin
    tv[0] = '{16'h0001, 16'h0100, 16'h0101, 16'h0101, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0002, 16'h0001, 16'hFFFF, 1'b1};
    tv[2] = '{16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 1'b1};
    tv[3] = '{16'hFFFE, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0};
    tv[4] = '{16'h1234, 16'h4321, 16'h5555, 16'h5555, 1'b0};
    b2.in_data = '0;
    b4.in_data = '0;
    do_reset();
    chk("rst_count", b4.out_count, 0);
    chk("rst_valid", b4.s_valid, 0);
    chk("rst_data", b4.s_data, 0);
    chk("rst_ovf", b4.ovf, 0);
    chk("rst_ready4", b4.in_ready, 4'hF);
    chk("rst_ready2", b2.in_ready, 2'b11);
    // two channels back to back: first output two edges after the first push, then one per cycle
    b2.s_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      b2.in_valid = 2'b11;
      b2.in_data = {16'(k << 8), 16'(k)};
      tick();
      if (k == 1) chk("b2b_latency", b2.s_valid, 0);
      else chk("b2b_sum", {b2.s_valid, b2.s_data}, {1'b1, 16'((k - 1) * 257)});
    end
    b2.in_valid = '0;
    tick();
    chk("b2b_last", {b2.s_valid, b2.s_data}, {1'b1, 16'(20 * 257)});
    tick();
    chk("b2b_empty", b2.s_valid, 0);
    // wrap vs saturate and sticky overflow, one pair per reset
    for (int j = 0; j < 5; j++) begin
      do_reset();
      b2.in_data = {tv[j].b, tv[j].a};
      b2.in_valid = 2'b11;
      tick();
      b2.in_valid = '0;
      tick();
      chk("tbl_count", b2.out_count, 1);
      chk("tbl_wrap", {b2.s_valid, b2.s_data}, {1'b1, tv[j].wrap});
      chk("tbl_sat", {b2s.s_valid, b2s.s_data}, {1'b1, tv[j].sat});
      chk("tbl_ovf", {b2.ovf, b2s.ovf}, {tv[j].ovf, tv[j].ovf});
      b2.s_ready = 1'b1;
      tick();
      b2.s_ready = 1'b0;
      tick();
      tick();
      chk("tbl_ovf_sticky", {b2.ovf, b2s.ovf}, {tv[j].ovf, tv[j].ovf});
      chk("tbl_data_idle", b2.s_data, 0);
    end
    // consumer stalled: 16 sums buffered out, then 16 per input, then backpressure
    do_reset();
    b4.in_valid = 4'hF;
    for (int c = 1; c <= 40; c++) begin
      b4.in_data = {$urandom(), $urandom()};
      tick();
      chk("stall_ready", b4.in_ready, c < 32 ? 4'hF : 4'h0);
      chk("stall_count", b4.out_count, c - 1 < 16 ? c - 1 : 16);
    end
    for (int i = 0; i < 4; i++) chk("stall_pushes", push4[i], 32);
    b4.in_valid = '0;
    b4.s_ready = 1'b1;
    repeat (50) tick();
    chk("stall_pops", pops4, 32);
    chk("stall_left", e4.size(), 0);
    // channel 2 starved: nothing comes out, the other channels fill up
    do_reset();
    b4.s_ready = 1'b1;
    b4.in_valid = 4'b1011;
    for (int c = 0; c < 20; c++) begin
      b4.in_data = {$urandom(), $urandom()};
      tick();
      chk("starve_valid", b4.s_valid, 0);
    end
    chk("starve_ready", b4.in_ready, 4'b0100);
    b4.in_valid = 4'hF;
    repeat (20) begin
      b4.in_data = {$urandom(), $urandom()};
      tick();
    end
    b4.in_valid = '0;
    repeat (40) tick();
    chk("starve_pops", pops4, 20);
    chk("starve_left", e4.size(), 0);
    // random producers and consumer against the scoreboard
    do_reset();
    repeat (500) begin
      b4.in_valid = 4'($urandom_range(0, 15));
      b4.s_ready = 1'($urandom_range(0, 1));
      b4.in_data = {$urandom(), $urandom()};
      tick();
    end
    b4.in_valid = '0;
    b4.s_ready = 1'b1;
    repeat (40) tick();
    chk("rand_left", e4.size(), 0);
    chk("rand_idle", b4.s_valid, 0);
    // reset pulse with overflowing data buffered
    do_reset();
    b4.in_valid = 4'hF;
    b4.in_data = {4{16'hFFFF}};
    repeat (5) tick();
    b4.in_valid = '0;
    tick();
    chk("pre_rst_count", b4.out_count, 5);
    chk("pre_rst_ovf", b4.ovf, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_valid", b4.s_valid, 0);
    chk("post_rst_count", b4.out_count, 0);
    chk("post_rst_ovf", b4.ovf, 0);
    chk("post_rst_ready", b4.in_ready, 4'hF);
    b4.s_ready = 1'b1;
    b4.in_valid = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      b4.in_data = {16'(k), 16'(k * 2), 16'(k * 3), 16'(k * 4)};
      tick();
    end
    b4.in_valid = '0;
    repeat (10) tick();
    chk("post_rst_pops", pops4, 3);
    chk("post_rst_ovf_clear", b4.ovf, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
